// File: rtl/reflet_rom_loader_pkg.sv
// Shared definitions for the Reflet boot loader: FSM state encoding and the
// image magic that the assembler also writes at the start of every ROM image.
package reflet_rom_loader_pkg;

    typedef enum logic [2:0] {
        LOADER_IDLE  = 3'd0,
        LOADER_CHECK = 3'd1,
        LOADER_COPY  = 3'd2,
        LOADER_DONE  = 3'd3,
        LOADER_ERROR = 3'd4
    } loader_state_t;

    // "ASRM", most significant byte at ROM address 0
    localparam logic [31:0] LOADER_MAGIC = 32'h4153524D;

endpackage

// File: rtl/reflet_rom_loader.sv
// Boot sequencer: verifies the ROM magic header, then streams COPY_LEN bytes
// from ROM into RAM while holding the CPU in reset.
module reflet_rom_loader
    import reflet_rom_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 8,
    parameter int          COPY_LEN   = 256,
    parameter logic [31:0] MAGIC      = LOADER_MAGIC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    output logic                  rom_enable_out,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    // One extra counter bit so COPY_LEN = 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] LEN         = (ADDR_WIDTH+1)'(COPY_LEN);
    localparam logic [ADDR_WIDTH:0] CHK_LAST_RD = (ADDR_WIDTH+1)'(3);
    localparam logic [ADDR_WIDTH:0] CHK_DRAIN   = (ADDR_WIDTH+1)'(4);

    loader_state_t         state, state_nxt;
    logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] rom_addr_nxt, ram_addr_nxt;
    logic                  ram_we_nxt;
    logic                  mismatch, mismatch_nxt;

    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        logic [31:0] sh;
        sh = MAGIC << {idx, 3'b000};
        return sh[31:24];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= LOADER_IDLE;
            cnt      <= '0;
            rom_addr <= '0;
            ram_addr <= '0;
            ram_we   <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rom_addr <= rom_addr_nxt;
            ram_addr <= ram_addr_nxt;
            ram_we   <= ram_we_nxt;
            mismatch <= mismatch_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rom_addr_nxt = rom_addr;
        ram_addr_nxt = ram_addr;
        ram_we_nxt   = 1'b0;
        mismatch_nxt = mismatch;

        case (state)
            LOADER_IDLE: begin
                state_nxt    = LOADER_CHECK;
                cnt_nxt      = '0;
                rom_addr_nxt = '0;
                mismatch_nxt = 1'b0;
            end

            LOADER_CHECK: begin
                // cnt counts CHECK cycles; the byte read at cnt-1 arrives now.
                cnt_nxt = cnt + 1'b1;
                if (cnt < CHK_LAST_RD)
                    rom_addr_nxt = rom_addr + 1'b1;
                if (cnt != '0 && rom_data != magic_byte(cnt[1:0] - 2'd1))
                    mismatch_nxt = 1'b1;
                if (cnt == CHK_DRAIN) begin
                    state_nxt    = mismatch_nxt ? LOADER_ERROR : LOADER_COPY;
                    cnt_nxt      = '0;
                    rom_addr_nxt = '0;
                end
            end

            LOADER_COPY: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt < LEN) begin
                    ram_we_nxt   = 1'b1;
                    ram_addr_nxt = rom_addr;
                end
                // Hold the last address instead of wrapping to 0.
                if (cnt + 1'b1 < LEN)
                    rom_addr_nxt = rom_addr + 1'b1;
                if (cnt == LEN)
                    state_nxt = LOADER_DONE;
            end

            LOADER_DONE, LOADER_ERROR: begin
                if (restart) begin
                    state_nxt    = LOADER_IDLE;
                    rom_addr_nxt = '0;
                    ram_addr_nxt = '0;
                end
            end

            default: state_nxt = LOADER_IDLE;
        endcase
    end

    assign rom_enable_out = (state == LOADER_CHECK) || (state == LOADER_COPY);
    assign ram_wdata      = rom_data;
    assign done           = (state == LOADER_DONE);
    assign cpu_hold       = (state != LOADER_DONE);
    assign error          = (state == LOADER_ERROR);

endmodule

// File: tb/tb_reflet_rom_loader.sv
// Bench for reflet_rom_loader: two instances (133-byte and 256-byte copies)
// driven by synchronous ROM models and checked against a cycle-level model.
module tb_reflet_rom_loader;

    localparam int          LEN_A = 133;
    localparam int          LEN_B = 256;
    localparam logic [31:0] MAGIC = 32'h4153524D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, restart_a, ren_a, we_a, hold_a, done_a, err_a;
    logic [7:0] raddr_a, rdata_a, waddr_a, wdata_a, romq_a;
    logic [7:0] rom_a [256];

    logic       rst_b, restart_b, ren_b, we_b, hold_b, done_b, err_b;
    logic [7:0] raddr_b, rdata_b, waddr_b, wdata_b, romq_b;
    logic [7:0] rom_b [256];

    always @(posedge clk) romq_a <= rom_a[raddr_a];
    always @(posedge clk) romq_b <= rom_b[raddr_b];
    assign rdata_a = ren_a ? romq_a : 8'h00;
    assign rdata_b = ren_b ? romq_b : 8'h00;

    reflet_rom_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .COPY_LEN(LEN_A), .MAGIC(MAGIC)) dut_a (
        .clk(clk), .reset(rst_a), .restart(restart_a),
        .rom_enable_out(ren_a), .rom_addr(raddr_a), .rom_data(rdata_a),
        .ram_we(we_a), .ram_addr(waddr_a), .ram_wdata(wdata_a),
        .cpu_hold(hold_a), .done(done_a), .error(err_a)
    );

    reflet_rom_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .COPY_LEN(LEN_B), .MAGIC(MAGIC)) dut_b (
        .clk(clk), .reset(rst_b), .restart(restart_b),
        .rom_enable_out(ren_b), .rom_addr(raddr_b), .rom_data(rdata_b),
        .ram_we(we_b), .ram_addr(waddr_b), .ram_wdata(wdata_b),
        .cpu_hold(hold_b), .done(done_b), .error(err_b)
    );

    typedef struct packed {
        logic       ren, we, dn, hold, err;
        logic [7:0] raddr, waddr, wdata, rdata;
    } snap_t;

    snap_t sa [512];
    snap_t sb [512];
    int    cyc;
    int    checks = 0;
    int    errors = 0;

    // Reference: per-cycle {rom_enable, ram_we, done, cpu_hold, error} from
    // the position t within one boot sequence (t = 0 is the IDLE cycle).
    function automatic logic [4:0] m_ctl(input int t, input int len, input bit good);
        bit ren, we, dn, er;
        ren = good ? (t >= 1 && t <= 6 + len) : (t >= 1 && t <= 5);
        we  = good && t >= 7 && t <= 6 + len;
        dn  = good && t >= 7 + len;
        er  = !good && t >= 6;
        return {ren, we, dn, !dn, er};
    endfunction

    function automatic logic [4:0] ctl(input snap_t s);
        return {s.ren, s.we, s.dn, s.hold, s.err};
    endfunction

    task automatic snap();
        if (cyc >= 0 && cyc < 512) begin
            sa[cyc] = '{ren_a, we_a, done_a, hold_a, err_a, raddr_a, waddr_a, wdata_a, rdata_a};
            sb[cyc] = '{ren_b, we_b, done_b, hold_b, err_b, raddr_b, waddr_b, wdata_b, rdata_b};
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            snap();
        end
    endtask

    task automatic release_a();
        @(negedge clk);
        rst_a = 1'b0;
        cyc = 0;
        snap();
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        restart_a = 1'b0;
        release_a();
    endtask

    task automatic reset_b();
        @(negedge clk);
        rst_b = 1'b1;
        restart_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        cyc = 0;
        snap();
    endtask

    task automatic load_a(input int bad_k);
        for (int i = 0; i < 256; i++) rom_a[i] = 8'($urandom);
        rom_a[0] = 8'h41; rom_a[1] = 8'h53; rom_a[2] = 8'h52; rom_a[3] = 8'h4D;
        rom_a[4] = 8'h14; rom_a[5] = 8'h3C; rom_a[132] = 8'h41;
        if (bad_k == 2) rom_a[2] = 8'h00;
        else if (bad_k >= 0) rom_a[bad_k] = rom_a[bad_k] ^ 8'(1 << $urandom_range(7, 0));
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; restart_a = 1'b1; restart_b = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        checks++;
        if ({ren_a, we_a, done_a, hold_a, err_a} !== 5'b00010) begin
            errors++; $display("FAIL reset_ctl_a got=%b exp=00010", {ren_a, we_a, done_a, hold_a, err_a});
        end
        checks++;
        if ({raddr_a, waddr_a} !== 16'h0000) begin
            errors++; $display("FAIL reset_addr_a got=%h exp=0000", {raddr_a, waddr_a});
        end
        checks++;
        if ({ren_b, we_b, done_b, hold_b, err_b} !== 5'b00010) begin
            errors++; $display("FAIL reset_ctl_b got=%b exp=00010", {ren_b, we_b, done_b, hold_b, err_b});
        end
        checks++;
        if ({raddr_b, waddr_b} !== 16'h0000) begin
            errors++; $display("FAIL reset_addr_b got=%h exp=0000", {raddr_b, waddr_b});
        end
        restart_a = 1'b0;
    endtask

    task automatic test_nominal();
        int nw;
        logic [7:0] ram [256];
        load_a(-1);
        reset_a();
        tick(146);
        nw = 0;
        for (int t = 0; t <= 146; t++) begin
            checks++;
            if (ctl(sa[t]) !== m_ctl(t, LEN_A, 1'b1)) begin
                errors++; $display("FAIL nominal_ctl cyc=%0d got=%b exp=%b", t, ctl(sa[t]), m_ctl(t, LEN_A, 1'b1));
            end
            if (t >= 1 && t <= 5) begin
                checks++;
                if (sa[t].raddr !== 8'((t - 1 < 3) ? t - 1 : 3)) begin
                    errors++; $display("FAIL check_rom_addr cyc=%0d got=%0d", t, sa[t].raddr);
                end
            end
            if (!sa[t].ren) begin
                checks++;
                if (sa[t].rdata !== 8'h00) begin
                    errors++; $display("FAIL rom_gating cyc=%0d got=%h exp=00", t, sa[t].rdata);
                end
            end
            if (sa[t].we) begin
                checks++;
                if ({sa[t].waddr, sa[t].wdata} !== {8'(nw), rom_a[nw]}) begin
                    errors++; $display("FAIL nominal_write cyc=%0d got=%h/%h exp=%h/%h",
                                       t, sa[t].waddr, sa[t].wdata, 8'(nw), rom_a[nw]);
                end
                ram[sa[t].waddr] = sa[t].wdata;
                nw++;
            end
        end
        checks++;
        if (nw != LEN_A) begin errors++; $display("FAIL nominal_count got=%0d exp=%0d", nw, LEN_A); end
        checks++;
        if ({ram[0], ram[4], ram[132]} !== 24'h411441) begin
            errors++; $display("FAIL nominal_ram got=%h exp=411441", {ram[0], ram[4], ram[132]});
        end
        checks++;
        if ({sa[139].dn, sa[140].dn, sa[140].hold} !== 3'b010) begin
            errors++; $display("FAIL nominal_done_edge got=%b exp=010", {sa[139].dn, sa[140].dn, sa[140].hold});
        end
    endtask

    task automatic test_bad_magic();
        int nw;
        for (int k = 0; k < 4; k++) begin
            load_a(k);
            reset_a();
            tick(30);
            nw = 0;
            for (int t = 0; t <= 30; t++) begin
                checks++;
                if (ctl(sa[t]) !== m_ctl(t, LEN_A, 1'b0)) begin
                    errors++; $display("FAIL bad_magic_ctl k=%0d cyc=%0d got=%b exp=%b",
                                       k, t, ctl(sa[t]), m_ctl(t, LEN_A, 1'b0));
                end
                if (sa[t].we) nw++;
            end
            checks++;
            if (nw != 0) begin errors++; $display("FAIL bad_magic_writes k=%0d got=%0d exp=0", k, nw); end
        end
    endtask

    task automatic test_restart_from_error();
        int nw;
        load_a(1);
        reset_a();
        tick(10);
        load_a(-1);
        restart_a = 1'b1;
        tick(1);
        restart_a = 1'b0;
        tick(145);
        nw = 0;
        for (int t = 11; t <= 156; t++) begin
            checks++;
            if (ctl(sa[t]) !== m_ctl(t - 11, LEN_A, 1'b1)) begin
                errors++; $display("FAIL err_restart_ctl cyc=%0d got=%b exp=%b", t, ctl(sa[t]), m_ctl(t - 11, LEN_A, 1'b1));
            end
            if (sa[t].we) nw++;
        end
        checks++;
        if ({sa[10].err, sa[11].err, sa[11].hold} !== 3'b101) begin
            errors++; $display("FAIL err_restart_edge got=%b exp=101", {sa[10].err, sa[11].err, sa[11].hold});
        end
        checks++;
        if (nw != LEN_A) begin errors++; $display("FAIL err_restart_count got=%0d exp=%0d", nw, LEN_A); end
    endtask

    task automatic test_full_space();
        int nw, last_t, zero_rw;
        for (int i = 0; i < 256; i++) rom_b[i] = 8'($urandom);
        rom_b[0] = 8'h41; rom_b[1] = 8'h53; rom_b[2] = 8'h52; rom_b[3] = 8'h4D;
        reset_b();
        tick(270);
        nw = 0; last_t = -1; zero_rw = 0;
        for (int t = 0; t <= 270; t++) begin
            checks++;
            if (ctl(sb[t]) !== m_ctl(t, LEN_B, 1'b1)) begin
                errors++; $display("FAIL full_ctl cyc=%0d got=%b exp=%b", t, ctl(sb[t]), m_ctl(t, LEN_B, 1'b1));
            end
            if (sb[t].we) begin
                checks++;
                if ({sb[t].waddr, sb[t].wdata} !== {8'(nw), rom_b[nw % 256]}) begin
                    errors++; $display("FAIL full_write cyc=%0d got=%h/%h exp=%h/%h",
                                       t, sb[t].waddr, sb[t].wdata, 8'(nw), rom_b[nw % 256]);
                end
                if (sb[t].waddr == 8'h00 && t != 7) zero_rw++;
                last_t = t;
                nw++;
            end
        end
        checks++;
        if (nw != LEN_B) begin errors++; $display("FAIL full_count got=%0d exp=%0d", nw, LEN_B); end
        checks++;
        if (last_t != 262 || sb[262].waddr !== 8'hFF) begin
            errors++; $display("FAIL full_last_write got=cyc%0d/%h exp=cyc262/ff", last_t, sb[262].waddr);
        end
        checks++;
        if (zero_rw != 0) begin errors++; $display("FAIL full_addr0_rewrite got=%0d exp=0", zero_rw); end
        checks++;
        if ({sb[262].dn, sb[263].dn} !== 2'b01) begin
            errors++; $display("FAIL full_done_edge got=%b exp=01", {sb[262].dn, sb[263].dn});
        end
    endtask

    task automatic test_reset_mid_copy();
        int nw;
        load_a(-1);
        reset_a();
        tick(50);
        checks++;
        if (we_a !== 1'b1) begin errors++; $display("FAIL midcopy_pre_we got=%b exp=1", we_a); end
        #2 rst_a = 1'b1;
        #1;
        checks++;
        if ({we_a, ren_a, hold_a, done_a} !== 4'b0010) begin
            errors++; $display("FAIL midcopy_async got=%b exp=0010", {we_a, ren_a, hold_a, done_a});
        end
        release_a();
        tick(141);
        nw = 0;
        for (int t = 0; t <= 141; t++) begin
            checks++;
            if (ctl(sa[t]) !== m_ctl(t, LEN_A, 1'b1)) begin
                errors++; $display("FAIL midcopy_rerun_ctl cyc=%0d got=%b exp=%b", t, ctl(sa[t]), m_ctl(t, LEN_A, 1'b1));
            end
            if (sa[t].we) begin
                checks++;
                if ({sa[t].waddr, sa[t].wdata} !== {8'(nw), rom_a[nw]}) begin
                    errors++; $display("FAIL midcopy_write cyc=%0d got=%h/%h", t, sa[t].waddr, sa[t].wdata);
                end
                nw++;
            end
        end
        checks++;
        if (nw != LEN_A) begin errors++; $display("FAIL midcopy_count got=%0d exp=%0d", nw, LEN_A); end
    endtask

    task automatic test_restart();
        int nw, pos;
        load_a(-1);
        reset_a();
        tick(60);
        restart_a = 1'b1;
        tick(1);
        restart_a = 1'b0;
        tick(89);
        restart_a = 1'b1;
        tick(1);
        restart_a = 1'b0;
        tick(145);
        nw = 0;
        for (int t = 0; t <= 296; t++) begin
            pos = (t <= 150) ? t : t - 151;
            checks++;
            if (ctl(sa[t]) !== m_ctl(pos, LEN_A, 1'b1)) begin
                errors++; $display("FAIL restart_ctl cyc=%0d got=%b exp=%b", t, ctl(sa[t]), m_ctl(pos, LEN_A, 1'b1));
            end
            if (sa[t].we) begin
                checks++;
                if ({sa[t].waddr, sa[t].wdata} !== {8'(nw % LEN_A), rom_a[nw % LEN_A]}) begin
                    errors++; $display("FAIL restart_write cyc=%0d got=%h/%h", t, sa[t].waddr, sa[t].wdata);
                end
                nw++;
            end
        end
        checks++;
        if (nw != 2 * LEN_A) begin errors++; $display("FAIL restart_count got=%0d exp=%0d", nw, 2 * LEN_A); end
        checks++;
        if ({sa[140].dn, sa[150].dn, sa[151].dn, sa[151].hold} !== 4'b1101) begin
            errors++; $display("FAIL restart_edge got=%b exp=1101", {sa[140].dn, sa[150].dn, sa[151].dn, sa[151].hold});
        end
        checks++;
        if ({sa[290].dn, sa[291].dn, sa[291].hold} !== 3'b010) begin
            errors++; $display("FAIL restart_second_done got=%b exp=010", {sa[290].dn, sa[291].dn, sa[291].hold});
        end
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_nominal();
        test_bad_magic();
        test_restart_from_error();
        test_full_space();
        test_reset_mid_copy();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
